puzzle_move_controller: RTL and testbench
=========================================

Name: puzzle_move_controller

Overview:
- Sequences the 4x4 sliding-puzzle board datapath.
- Turns one-cycle direction requests into legal single-tile moves. It drives the datapath's moveFrom/moveTo (1-based block index), then runs a two-step redraw handshake with the tile drawer, first the vacated block and then the filled block.
- Also counts moves and latches the win condition.
- Sits between the keyboard/key-debounce front end and the board datapath plus draw engine.

Parameters:
- TILE_PITCH, 29, pixel pitch between block origins in x and y.
- CNT_W, 10, move counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- init_blank  in  5  block index (1..16) of the blank in the initial board; sampled during reset
- dir_up  in  1  pulse: the tile below the blank moves up
- dir_down  in  1  pulse: the tile above the blank moves down
- dir_left  in  1  pulse: the tile right of the blank moves left
- dir_right  in  1  pulse: the tile left of the blank moves right
- board_state  in  64  datapath blockState; nibble i-1 holds block i
- win_in  in  1  datapath ifWin
- draw_done  in  1  draw engine finished the current tile
- move_from  out  5  to datapath moveFrom
- move_to  out  5  to datapath moveTo
- draw_req  out  1  draw request, level, held until draw_done
- draw_x  out  8  block origin x
- draw_y  out  7  block origin y
- draw_num  out  4  tile value to draw (0 = blank)
- busy  out  1  high in any state other than IDLE and WON
- illegal  out  1  one-cycle pulse when a request is rejected
- move_count  out  CNT_W  accepted moves since reset, saturating
- won  out  1  latched win

Behaviour:
Reset (synchronous, active-low):
- blank_pos <= init_blank; state <= IDLE; move_count <= 0.
- won, illegal and draw_req are 0.
- move_from = move_to = init_blank; draw_x, draw_y and draw_num are 0.
- Reset mid-operation aborts any pending draw immediately.

Idle convention:
- Outside MOVE, move_from = move_to = blank_pos.
- Because that block holds 0, the datapath performs no move.

Request decode, in IDLE only:
- Exactly one dir_* high is required. Zero requests do nothing.
- Two or more simultaneous requests pulse illegal and are otherwise ignored.
- With b = blank_pos, r = (b-1)/4 and c = (b-1)%4:
  - up: legal iff r<3; src = b+4.
  - down: legal iff r>0; src = b-4.
  - left: legal iff c<3; src = b+1.
  - right: legal iff c>0; src = b-1.
- A legal request latches src and dst = b, then goes to MOVE.
- An illegal request pulses illegal next cycle and stays in IDLE.
- dir_* in any other state is dropped, not queued.

State machine:
- MOVE (1 cycle)
  - move_from = src, move_to = dst; the datapath commits on this edge.
  - blank_pos <= src.
  - move_count++, holding at all-ones.
  - Next state: DRAW_BLANK.
- DRAW_BLANK
  - draw_req = 1; draw_x = ((src-1)%4)*TILE_PITCH; draw_y = ((src-1)/4)*TILE_PITCH; draw_num = 0.
  - On draw_done while draw_req is high: DRAW_GAP.
- DRAW_GAP (1 cycle): draw_req = 0, guaranteeing a request edge. Next state: DRAW_TILE.
- DRAW_TILE
  - draw_req = 1; origin is computed from dst; draw_num = board_state[(dst-1)*4 +: 4], the value just moved.
  - On draw_done: CHECK.
- CHECK (1 cycle): if win_in, set won = 1 and go to WON; else go to IDLE.
  - win_in is stable here because the datapath registered the move at least 3 cycles earlier.
- WON
  - Terminal until reset.
  - All dir_* are ignored with no illegal pulse.
  - move_from = move_to = blank_pos.

Other rules:
- draw_done outside DRAW_BLANK and DRAW_TILE is ignored.
- Origin arithmetic is done at 8 bits; max x = 3*29 = 87 and max y = 87, so nothing overflows.
- Index arithmetic is only ever evaluated for legal moves, so src is always in 1..16.

Decomposition:
- Shared package puzzle_pkg holds:
  - state enum: IDLE, MOVE, DRAW_BLANK, DRAW_GAP, DRAW_TILE, CHECK, WON;
  - TILE_PITCH, GRID_DIM = 4, BLANK_VAL = 4'd0;
  - the direction encoding.
- Sub-module puzzle_move_decode (combinational): blank_pos plus one-hot direction in, legal/src out. Verified standalone over all 16 positions x 4 directions.

Test Plan:
- Reset with init_blank=16, then dir_down pulse -> MOVE cycle with move_from=12, move_to=16. Then DRAW_BLANK at (87,58) num 0, then DRAW_TILE at (87,87) with board value. Afterwards move_count=1 and idle move_from=move_to=12.
- init_blank=16, dir_up -> illegal pulses 1 cycle, no MOVE, move_count stays 0. Same result for dir_left at blank 4 and dir_right at blank 13.
- dir_up and dir_left asserted together in IDLE -> illegal pulse, no state change.
- dir_left pulse during DRAW_BLANK with draw_done delayed 20 cycles -> request dropped. draw_req stays high until draw_done, then a 1-cycle low gap, then high for DRAW_TILE.
- Board solved except blank at 15 with tile 15 at 16, init_blank=15, dir_left -> CHECK sees win_in=1 and won=1. Subsequent dir_* produce no move and no illegal pulse.
- Assert resetn=0 during DRAW_TILE -> next cycle draw_req=0, move_count=0, won=0, blank_pos=init_blank.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types and constants for the sliding-puzzle move controller.
package puzzle_pkg;

  localparam int unsigned TILE_PITCH = 29;
  localparam int unsigned GRID_DIM   = 4;
  localparam logic [3:0]  BLANK_VAL  = 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    DRAW_BLANK,
    DRAW_GAP,
    DRAW_TILE,
    CHECK,
    WON
  } state_t;

  // One-hot direction vector, bit order {right, left, down, up}
  typedef enum logic [3:0] {
    DIR_UP    = 4'b0001,
    DIR_DOWN  = 4'b0010,
    DIR_LEFT  = 4'b0100,
    DIR_RIGHT = 4'b1000
  } dir_t;

  function automatic logic [1:0] rowOf(input logic [4:0] pos);
    logic [4:0] idx;
    idx = pos - 5'd1;
    return idx[3:2];
  endfunction

  function automatic logic [1:0] colOf(input logic [4:0] pos);
    logic [4:0] idx;
    idx = pos - 5'd1;
    return idx[1:0];
  endfunction

endpackage

// File: rtl/puzzle_move_controller_if.sv
// Redraw handshake between the move controller and the tile drawer.
interface puzzle_move_controller_if;
  logic       draw_req;
  logic [7:0] draw_x;
  logic [6:0] draw_y;
  logic [3:0] draw_num;
  logic       draw_done;

  modport master (output draw_req, draw_x, draw_y, draw_num, input draw_done);
  modport slave  (input draw_req, draw_x, draw_y, draw_num, output draw_done);
endinterface

// File: rtl/puzzle_move_decode.sv
// Combinational legality check and source block for a one-hot direction request.
module puzzle_move_decode
  import puzzle_pkg::*;
(
  input  logic [4:0] blankPos,
  input  logic [3:0] dirOneHot,
  output logic       legal,
  output logic [4:0] src
);

  localparam logic [1:0] LAST = 2'(GRID_DIM - 1);
  localparam logic [4:0] STEP = 5'(GRID_DIM);

  logic [1:0] row;
  logic [1:0] col;

  always_comb begin
    row   = rowOf(blankPos);
    col   = colOf(blankPos);
    legal = 1'b0;
    src   = blankPos;
    // Non-one-hot vectors fall to default and are never legal
    case (dirOneHot)
      DIR_UP:    begin legal = (row != LAST);  src = blankPos + STEP; end
      DIR_DOWN:  begin legal = (row != 2'd0);  src = blankPos - STEP; end
      DIR_LEFT:  begin legal = (col != LAST);  src = blankPos + 5'd1; end
      DIR_RIGHT: begin legal = (col != 2'd0);  src = blankPos - 5'd1; end
      default:   begin legal = 1'b0;           src = blankPos;        end
    endcase
  end

endmodule

// File: rtl/puzzle_move_controller.sv
// Turns direction pulses into single-tile board moves, sequences the two-tile
// redraw, counts moves and latches the win condition.
module puzzle_move_controller
  import puzzle_pkg::*;
#(
  parameter int unsigned TILE_PITCH = puzzle_pkg::TILE_PITCH,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [4:0]               init_blank,
  input  logic                     dir_up,
  input  logic                     dir_down,
  input  logic                     dir_left,
  input  logic                     dir_right,
  input  logic [63:0]              board_state,
  input  logic                     win_in,
  puzzle_move_controller_if.master draw,
  output logic [4:0]               move_from,
  output logic [4:0]               move_to,
  output logic                     busy,
  output logic                     illegal,
  output logic [CNT_W-1:0]         move_count,
  output logic                     won
);

  localparam logic [7:0] PITCH8 = 8'(TILE_PITCH);

  state_t     state, nextState;
  logic [4:0] blankPos, srcPos, dstPos;
  logic [3:0] dirVec;
  logic       decLegal;
  logic [4:0] decSrc;
  logic [4:0] drawPos;
  logic [4:0] dstIdx;
  logic [7:0] originX, originY;

  assign dirVec = {dir_right, dir_left, dir_down, dir_up};
  assign dstIdx = dstPos - 5'd1;

  puzzle_move_decode u_decode (
    .blankPos  (blankPos),
    .dirOneHot (dirVec),
    .legal     (decLegal),
    .src       (decSrc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState     = state;
    move_from     = blankPos;
    move_to       = blankPos;
    draw.draw_req = 1'b0;
    draw.draw_num = BLANK_VAL;
    drawPos       = dstPos;
    case (state)
      IDLE:       if (decLegal) nextState = MOVE;
      MOVE: begin
        move_from = srcPos;
        move_to   = dstPos;
        nextState = DRAW_BLANK;
      end
      DRAW_BLANK: begin
        draw.draw_req = 1'b1;
        drawPos       = srcPos;
        if (draw.draw_done) nextState = DRAW_GAP;
      end
      DRAW_GAP:   nextState = DRAW_TILE;
      DRAW_TILE: begin
        draw.draw_req = 1'b1;
        draw.draw_num = board_state[{dstIdx[3:0], 2'b00} +: 4];
        if (draw.draw_done) nextState = CHECK;
      end
      CHECK:      nextState = win_in ? WON : IDLE;
      WON:        nextState = WON;
      default:    nextState = IDLE;
    endcase
  end

  assign originX = {6'd0, colOf(drawPos)} * PITCH8;
  assign originY = {6'd0, rowOf(drawPos)} * PITCH8;
  assign draw.draw_x = draw.draw_req ? originX : '0;
  assign draw.draw_y = draw.draw_req ? originY[6:0] : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      blankPos   <= init_blank;
      srcPos     <= init_blank;
      dstPos     <= init_blank;
      move_count <= '0;
      won        <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      // Multi-bit requests decode as illegal, so one term covers both rejections
      illegal <= (state == IDLE) && (dirVec != '0) && !decLegal;
      if (state == IDLE && decLegal) begin
        srcPos <= decSrc;
        dstPos <= blankPos;
      end
      if (state == MOVE) begin
        blankPos <= srcPos;
        if (move_count != '1) move_count <= move_count + CNT_W'(1);
      end
      if (state == CHECK && win_in) won <= 1'b1;
    end
  end

  assign busy = (state != IDLE) && (state != WON);

endmodule

// File: tb/tb_puzzle_move_controller.sv
// Randomized self-checking bench with a grid-coordinate reference model and a board datapath model.
module tb_puzzle_move_controller;
  import puzzle_pkg::*;

  localparam int unsigned CNT_W = 10;
  localparam int          PITCH = 29;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [4:0]       init_blank = 5'd16;
  logic             dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
  logic [63:0]      board_state;
  logic             win_in;
  logic [4:0]       move_from, move_to;
  logic             busy, illegal, won;
  logic [CNT_W-1:0] move_count;

  puzzle_move_controller_if drawBus ();

  puzzle_move_controller #(.TILE_PITCH(PITCH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .init_blank  (init_blank),
    .dir_up      (dir_up),
    .dir_down    (dir_down),
    .dir_left    (dir_left),
    .dir_right   (dir_right),
    .board_state (board_state),
    .win_in      (win_in),
    .draw        (drawBus),
    .move_from   (move_from),
    .move_to     (move_to),
    .busy        (busy),
    .illegal     (illegal),
    .move_count  (move_count),
    .won         (won)
  );

  always #5 clk = ~clk;

  // Board datapath model: blocks 1..16, value 0 is the blank
  int   brd[1:16];
  int   rstBrd[1:16];
  logic [4:0] pendFrom = 5'd16, pendTo = 5'd16;

  always @(negedge clk) begin
    pendFrom <= move_from;
    pendTo   <= move_to;
  end

  always @(posedge clk) begin
    if (!resetn) begin
      for (int p = 1; p <= 16; p++) brd[p] <= rstBrd[p];
    end else if (pendFrom != pendTo) begin
      brd[pendTo]   <= brd[pendFrom];
      brd[pendFrom] <= 0;
    end
  end

  always_comb begin
    board_state = '0;
    win_in      = 1'b1;
    for (int p = 1; p <= 16; p++) begin
      board_state[(p-1)*4 +: 4] = 4'(brd[p]);
      if (brd[p] != p % 16) win_in = 1'b0;
    end
  end

  // Reference model state
  int eRow, eCol, eCount;
  bit eWon;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit boardSolved();
    for (int p = 1; p <= 16; p++) if (brd[p] != p % 16) return 1'b0;
    return 1'b1;
  endfunction

  task automatic setDirs(input logic [3:0] dv);
    {dir_right, dir_left, dir_down, dir_up} = dv;
  endtask

  task automatic applyReset(input int b);
    for (int p = 1; p <= 16; p++) rstBrd[p] = p % 16;
    if (b != 16) begin
      rstBrd[16] = b;
      rstBrd[b]  = 0;
    end
    init_blank = 5'(b);
    setDirs(4'b0000);
    drawBus.draw_done = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    eRow = (b - 1) / 4;
    eCol = (b - 1) % 4;
    eCount = 0;
    eWon = 1'b0;
    chk("rst_from", move_from, b);
    chk("rst_to", move_to, b);
    chk("rst_req", drawBus.draw_req, 0);
    chk("rst_count", move_count, 0);
    chk("rst_won", won, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
  endtask

  task automatic request(input logic [3:0] dv, input int dBlank, input int dTile,
                         input logic [3:0] injectDv);
    int n, sr, sc, bPos, sPos, tileVal;
    bit legal;
    n  = $countones(dv);
    sr = eRow;
    sc = eCol;
    if (dv[0]) sr = eRow + 1;
    if (dv[1]) sr = eRow - 1;
    if (dv[2]) sc = eCol + 1;
    if (dv[3]) sc = eCol - 1;
    legal = (n == 1) && sr >= 0 && sr <= 3 && sc >= 0 && sc <= 3;
    bPos = eRow * 4 + eCol + 1;
    sPos = sr * 4 + sc + 1;
    tileVal = legal ? brd[sPos] : 0;

    setDirs(dv);
    if (n == 0) drawBus.draw_done = 1'b1;
    @(negedge clk);
    setDirs(4'b0000);
    drawBus.draw_done = 1'b0;

    if (eWon || n == 0) begin
      chk("noop_busy", busy, 0);
      chk("noop_from", move_from, bPos);
      chk("noop_to", move_to, bPos);
      chk("noop_won", won, eWon);
      @(negedge clk);
      chk("noop_illegal", illegal, 0);
      chk("noop_count", move_count, eCount);
      return;
    end

    if (!legal) begin
      chk("illegal_pulse", illegal, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_from", move_from, bPos);
      @(negedge clk);
      chk("illegal_clear", illegal, 0);
      chk("illegal_count", move_count, eCount);
      chk("illegal_to", move_to, bPos);
      return;
    end

    chk("move_from", move_from, sPos);
    chk("move_to", move_to, bPos);
    chk("move_busy", busy, 1);
    chk("move_req", drawBus.draw_req, 0);
    if (eCount < (1 << CNT_W) - 1) eCount++;

    @(negedge clk);
    chk("blank_req", drawBus.draw_req, 1);
    chk("blank_x", drawBus.draw_x, sc * PITCH);
    chk("blank_y", drawBus.draw_y, sr * PITCH);
    chk("blank_num", drawBus.draw_num, 0);
    for (int i = 0; i < dBlank; i++) begin
      if (i == 0) setDirs(injectDv);
      @(negedge clk);
      setDirs(4'b0000);
      chk("blank_hold", drawBus.draw_req, 1);
      chk("blank_from", move_from, sPos);
    end
    drawBus.draw_done = 1'b1;
    @(negedge clk);
    drawBus.draw_done = 1'b0;
    chk("gap_req", drawBus.draw_req, 0);
    chk("gap_busy", busy, 1);

    @(negedge clk);
    chk("tile_req", drawBus.draw_req, 1);
    chk("tile_x", drawBus.draw_x, eCol * PITCH);
    chk("tile_y", drawBus.draw_y, eRow * PITCH);
    chk("tile_num", drawBus.draw_num, tileVal);
    for (int i = 0; i < dTile; i++) begin
      @(negedge clk);
      chk("tile_hold", drawBus.draw_req, 1);
    end
    drawBus.draw_done = 1'b1;
    @(negedge clk);
    drawBus.draw_done = 1'b0;
    chk("check_req", drawBus.draw_req, 0);
    chk("check_busy", busy, 1);

    eRow = sr;
    eCol = sc;
    eWon = boardSolved();
    @(negedge clk);
    chk("done_won", won, eWon);
    chk("done_busy", busy, 0);
    chk("done_count", move_count, eCount);
    chk("done_from", move_from, sPos);
    chk("done_to", move_to, sPos);
  endtask

  initial begin
    logic [3:0] dv;
    int sel;
    drawBus.draw_done = 1'b0;

    // Blank at corner: one legal move, then the three edge-illegal cases
    applyReset(16);
    request(4'b0010, 0, 0, 4'b0000);
    applyReset(16);
    request(4'b0001, 0, 0, 4'b0000);
    applyReset(4);
    request(4'b0100, 0, 0, 4'b0000);
    applyReset(13);
    request(4'b1000, 0, 0, 4'b0000);

    // Simultaneous requests
    applyReset(16);
    request(4'b0101, 0, 0, 4'b0000);
    applyReset(6);
    request(4'b0101, 0, 0, 4'b0000);

    // Request during a long blank redraw is dropped
    applyReset(6);
    request(4'b0001, 20, 3, 4'b0100);
    request(4'b0000, 0, 0, 4'b0000);

    // Winning move, then everything is ignored
    applyReset(15);
    request(4'b0100, 1, 1, 4'b0000);
    chk("win_latched", won, 1);
    request(4'b0010, 0, 0, 4'b0000);
    request(4'b1000, 0, 0, 4'b0000);
    request(4'b0011, 0, 0, 4'b0000);

    // Reset while the filled tile is being drawn
    applyReset(16);
    setDirs(4'b0010);
    @(negedge clk);
    setDirs(4'b0000);
    @(negedge clk);
    drawBus.draw_done = 1'b1;
    @(negedge clk);
    drawBus.draw_done = 1'b0;
    @(negedge clk);
    chk("midrst_tile_req", drawBus.draw_req, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_req", drawBus.draw_req, 0);
    chk("midrst_count", move_count, 0);
    chk("midrst_won", won, 0);
    chk("midrst_from", move_from, 16);
    chk("midrst_to", move_to, 16);
    resetn = 1'b1;
    @(negedge clk);
    eRow = 3; eCol = 3; eCount = 0; eWon = 1'b0;
    request(4'b1000, 0, 0, 4'b0000);

    // Random walk from random starting blanks
    applyReset($urandom_range(1, 16));
    for (int k = 0; k < 120; k++) begin
      if (eWon) applyReset($urandom_range(1, 16));
      sel = $urandom_range(0, 9);
      if (sel < 7)       dv = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 7) dv = 4'b0000;
      else               dv = 4'($urandom_range(0, 15));
      request(dv, $urandom_range(0, 4), $urandom_range(0, 4), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
